// File: rtl/axi2fifo.sv
// AXI4-Lite slave that turns write/read transactions into request FIFO pushes and
// returns the matching response FIFO entries on B/R. Optional: AXI2FIFO_WSTRB_CHECK_EN.
module axi2fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [ADDR_W-1:0] s_axi_awaddr_i,
  input  logic              s_axi_awvalid_i,
  output logic              s_axi_awready_o,
  input  logic [31:0]       s_axi_wdata_i,
  input  logic [3:0]        s_axi_wstrb_i,
  input  logic              s_axi_wvalid_i,
  output logic              s_axi_wready_o,
  output logic [1:0]        s_axi_bresp_o,
  output logic              s_axi_bvalid_o,
  input  logic              s_axi_bready_i,
  input  logic [ADDR_W-1:0] s_axi_araddr_i,
  input  logic              s_axi_arvalid_i,
  output logic              s_axi_arready_o,
  output logic [31:0]       s_axi_rdata_o,
  output logic [1:0]        s_axi_rresp_o,
  output logic              s_axi_rvalid_o,
  input  logic              s_axi_rready_i,
  input  logic              wr_req_full_i,
  output logic [1:0]        wr_req_data_o,
  output logic              wr_req_push_o,
  input  logic              wr_data_full_i,
  output logic [35:0]       wr_data_data_o,
  output logic              wr_data_push_o,
  input  logic              wr_resp_empty_i,
  input  logic [1:0]        wr_resp_data_i,
  output logic              wr_resp_pull_o,
  input  logic              rd_req_full_i,
  output logic [1:0]        rd_req_data_o,
  output logic              rd_req_push_o,
  input  logic              rd_resp_empty_i,
  input  logic [33:0]       rd_resp_data_i,
  output logic              rd_resp_pull_o
);

  typedef enum logic [1:0] {W_IDLE, W_PUSH, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_PUSH, R_WAIT, R_DATA} r_state_t;

  // ---------------- write path ----------------
  w_state_t    w_state, w_next;
  logic        aw_cap, w_cap, aw_cap_n, w_cap_n;
  logic        awready_q, wready_q;
  logic [1:0]  waddr_q, waddr_sel, wcode_q, wcode_n;
  logic [35:0] wdat_q;
  logic [1:0]  bresp_q;
  logic        aw_hs, w_hs, wr_push, wr_pull;

  assign aw_hs     = s_axi_awvalid_i & awready_q;
  assign w_hs      = s_axi_wvalid_i & wready_q;
  assign wr_push   = (w_state == W_PUSH) & ~wr_req_full_i & ~wr_data_full_i;
  assign wr_pull   = (w_state == W_WAIT) & ~wr_resp_empty_i;
  assign waddr_sel = aw_hs ? s_axi_awaddr_i[3:2] : waddr_q;

  // Status writes keep their address code (2), which is also the access-error code.
  always_comb begin
    wcode_n = waddr_sel;
`ifdef AXI2FIFO_WSTRB_CHECK_EN
    if ((w_hs ? s_axi_wstrb_i : wdat_q[3:0]) != 4'hF) wcode_n = 2'd2;
`endif
  end

  always_comb begin
    w_next   = w_state;
    aw_cap_n = aw_cap;
    w_cap_n  = w_cap;
    case (w_state)
      W_IDLE: begin
        aw_cap_n = aw_cap | aw_hs;
        w_cap_n  = w_cap | w_hs;
        if (aw_cap_n && w_cap_n) w_next = W_PUSH;
      end
      W_PUSH: if (wr_push) w_next = W_WAIT;
      W_WAIT: if (wr_pull) w_next = W_RESP;
      W_RESP: if (s_axi_bready_i) begin
        w_next   = W_IDLE;
        aw_cap_n = 1'b0;
        w_cap_n  = 1'b0;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Readies are registered from next-state so they are low while in reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_state   <= W_IDLE;
      aw_cap    <= 1'b0;
      w_cap     <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      waddr_q   <= '0;
      wcode_q   <= '0;
      wdat_q    <= '0;
      bresp_q   <= '0;
    end else begin
      w_state   <= w_next;
      aw_cap    <= aw_cap_n;
      w_cap     <= w_cap_n;
      awready_q <= (w_next == W_IDLE) & ~aw_cap_n;
      wready_q  <= (w_next == W_IDLE) & ~w_cap_n;
      if (aw_hs) waddr_q <= s_axi_awaddr_i[3:2];
      if (w_hs) wdat_q <= {s_axi_wdata_i, s_axi_wstrb_i};
      if (w_state == W_IDLE && w_next == W_PUSH) wcode_q <= wcode_n;
      if (wr_pull) bresp_q <= wr_resp_data_i;
    end
  end

  assign s_axi_awready_o = awready_q;
  assign s_axi_wready_o  = wready_q;
  assign s_axi_bvalid_o  = (w_state == W_RESP);
  assign s_axi_bresp_o   = bresp_q;
  assign wr_req_data_o   = wcode_q;
  assign wr_req_push_o   = wr_push;
  assign wr_data_data_o  = wdat_q;
  assign wr_data_push_o  = wr_push;
  assign wr_resp_pull_o  = wr_pull;

  // ---------------- read path ----------------
  r_state_t    r_state, r_next;
  logic        arready_q;
  logic [1:0]  rcode_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        ar_hs, rd_push, rd_pull;

  assign ar_hs   = s_axi_arvalid_i & arready_q;
  assign rd_push = (r_state == R_PUSH) & ~rd_req_full_i;
  assign rd_pull = (r_state == R_WAIT) & ~rd_resp_empty_i;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_PUSH;
      R_PUSH:  if (rd_push) r_next = R_WAIT;
      R_WAIT:  if (rd_pull) r_next = R_DATA;
      R_DATA:  if (s_axi_rready_i) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rcode_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state   <= r_next;
      arready_q <= (r_next == R_IDLE);
      if (ar_hs) rcode_q <= s_axi_araddr_i[3:2];
      if (rd_pull) begin
        rdata_q <= rd_resp_data_i[33:2];
        rresp_q <= rd_resp_data_i[1:0];
      end
    end
  end

  assign s_axi_arready_o = arready_q;
  assign s_axi_rvalid_o  = (r_state == R_DATA);
  assign s_axi_rdata_o   = rdata_q;
  assign s_axi_rresp_o   = rresp_q;
  assign rd_req_data_o   = rcode_q;
  assign rd_req_push_o   = rd_push;
  assign rd_resp_pull_o  = rd_pull;

  // Only addr[3:2] is decoded; the remaining address bits are intentionally ignored.
  logic unused;
  assign unused = ^{s_axi_awaddr_i, s_axi_araddr_i};

endmodule

// File: tb/tb_axi2fifo.sv
// Scoreboard bench for axi2fifo: AXI master + FIFO models, expected pushes/responses
// queued at issue time and checked by a negedge monitor.
module tb_axi2fifo;
  localparam int ADDR_W = 4;
`ifdef AXI2FIFO_WSTRB_CHECK_EN
  localparam bit STRB_CHK = 1'b1;
`else
  localparam bit STRB_CHK = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic [ADDR_W-1:0] s_axi_awaddr_i = '0;
  logic              s_axi_awvalid_i = 1'b0;
  logic              s_axi_awready_o;
  logic [31:0]       s_axi_wdata_i = '0;
  logic [3:0]        s_axi_wstrb_i = '0;
  logic              s_axi_wvalid_i = 1'b0;
  logic              s_axi_wready_o;
  logic [1:0]        s_axi_bresp_o;
  logic              s_axi_bvalid_o;
  logic              s_axi_bready_i = 1'b0;
  logic [ADDR_W-1:0] s_axi_araddr_i = '0;
  logic              s_axi_arvalid_i = 1'b0;
  logic              s_axi_arready_o;
  logic [31:0]       s_axi_rdata_o;
  logic [1:0]        s_axi_rresp_o;
  logic              s_axi_rvalid_o;
  logic              s_axi_rready_i = 1'b0;
  logic              wr_req_full_i = 1'b0;
  logic [1:0]        wr_req_data_o;
  logic              wr_req_push_o;
  logic              wr_data_full_i = 1'b0;
  logic [35:0]       wr_data_data_o;
  logic              wr_data_push_o;
  logic              wr_resp_empty_i = 1'b1;
  logic [1:0]        wr_resp_data_i = '0;
  logic              wr_resp_pull_o;
  logic              rd_req_full_i = 1'b0;
  logic [1:0]        rd_req_data_o;
  logic              rd_req_push_o;
  logic              rd_resp_empty_i = 1'b1;
  logic [33:0]       rd_resp_data_i = '0;
  logic              rd_resp_pull_o;

  axi2fifo #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .s_axi_awaddr_i(s_axi_awaddr_i), .s_axi_awvalid_i(s_axi_awvalid_i), .s_axi_awready_o(s_axi_awready_o),
    .s_axi_wdata_i(s_axi_wdata_i), .s_axi_wstrb_i(s_axi_wstrb_i), .s_axi_wvalid_i(s_axi_wvalid_i),
    .s_axi_wready_o(s_axi_wready_o),
    .s_axi_bresp_o(s_axi_bresp_o), .s_axi_bvalid_o(s_axi_bvalid_o), .s_axi_bready_i(s_axi_bready_i),
    .s_axi_araddr_i(s_axi_araddr_i), .s_axi_arvalid_i(s_axi_arvalid_i), .s_axi_arready_o(s_axi_arready_o),
    .s_axi_rdata_o(s_axi_rdata_o), .s_axi_rresp_o(s_axi_rresp_o), .s_axi_rvalid_o(s_axi_rvalid_o),
    .s_axi_rready_i(s_axi_rready_i),
    .wr_req_full_i(wr_req_full_i), .wr_req_data_o(wr_req_data_o), .wr_req_push_o(wr_req_push_o),
    .wr_data_full_i(wr_data_full_i), .wr_data_data_o(wr_data_data_o), .wr_data_push_o(wr_data_push_o),
    .wr_resp_empty_i(wr_resp_empty_i), .wr_resp_data_i(wr_resp_data_i), .wr_resp_pull_o(wr_resp_pull_o),
    .rd_req_full_i(rd_req_full_i), .rd_req_data_o(rd_req_data_o), .rd_req_push_o(rd_req_push_o),
    .rd_resp_empty_i(rd_resp_empty_i), .rd_resp_data_i(rd_resp_data_i), .rd_resp_pull_o(rd_resp_pull_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // knobs
  int   full_pct = 0, resp_dly = 0;
  bit   rd_full_force = 1'b0, hold_bready = 1'b0, chk_wlat = 1'b0, chk_rlat = 1'b0;
  bit   b_fix_en = 1'b0, r_fix_en = 1'b0;
  logic [1:0]  b_fix_val = '0;
  logic [33:0] r_fix_val = '0;
  int   last_whs = 0, last_arhs = 0;
  int   n_wpush = 0, n_wpull = 0, n_rpush = 0, n_rpull = 0;

  // scoreboard / FIFO models
  logic [1:0]  exp_wreq[$];
  logic [35:0] exp_wdata[$];
  logic [1:0]  exp_rreq[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [1:0]  wresp_q[$];
  int          wresp_t[$];
  logic [33:0] rresp_q[$];
  int          rresp_t[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode: status writes and (optionally) partial strobes give the error code.
  function automatic logic [1:0] wcode(input logic [ADDR_W-1:0] a, input logic [3:0] s);
    logic [1:0] c;
    c = (a[3:2] == 2'd2) ? 2'd2 : a[3:2];
    if (STRB_CHK && s != 4'hF) c = 2'd2;
    return c;
  endfunction

  // FIFO-side driver: everything changes just after the rising edge.
  initial forever begin
    @(posedge clk_i); #1;
    wr_req_full_i   = int'($urandom_range(99)) < full_pct;
    wr_data_full_i  = int'($urandom_range(99)) < full_pct;
    rd_req_full_i   = rd_full_force || (int'($urandom_range(99)) < full_pct);
    s_axi_bready_i  = !hold_bready && ($urandom_range(2) != 0);
    s_axi_rready_i  = ($urandom_range(2) != 0);
    wr_resp_empty_i = !(wresp_q.size() > 0 && cyc >= wresp_t[0]);
    wr_resp_data_i  = (wresp_q.size() > 0) ? wresp_q[0] : 2'd0;
    rd_resp_empty_i = !(rresp_q.size() > 0 && cyc >= rresp_t[0]);
    rd_resp_data_i  = (rresp_q.size() > 0) ? rresp_q[0] : 34'd0;
  end

  // monitor
  bit          prev_wpull = 1'b0, prev_rpull = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
  logic [1:0]  b_hold, bv;
  logic [33:0] r_hold, rv;

  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (wr_req_push_o || wr_data_push_o) begin
        n_wpush++;
        chk("wr_push_pair", 64'({wr_req_push_o, wr_data_push_o}), 64'(2'b11));
        chk("wr_push_not_full", 64'(wr_req_full_i | wr_data_full_i), 64'(0));
        if (exp_wreq.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_push_unexpected: push seen, expected no push");
        end else begin
          chk("wr_req_data", 64'(wr_req_data_o), 64'(exp_wreq.pop_front()));
          chk("wr_data_data", 64'(wr_data_data_o), 64'(exp_wdata.pop_front()));
        end
        if (chk_wlat) chk("wr_push_latency", 64'(cyc), 64'(last_whs + 1));
        bv = b_fix_en ? b_fix_val : 2'($urandom_range(3));
        wresp_q.push_back(bv);
        wresp_t.push_back(cyc + 1 + int'($urandom_range(resp_dly)));
        exp_b.push_back(bv);
      end
      if (prev_wpull) chk("bvalid_after_pull", 64'(s_axi_bvalid_o), 64'(1));
      prev_wpull = wr_resp_pull_o;
      if (wr_resp_pull_o) begin
        n_wpull++;
        chk("wr_pull_not_empty", 64'(wr_resp_empty_i), 64'(0));
        if (wresp_q.size() > 0) begin void'(wresp_q.pop_front()); void'(wresp_t.pop_front()); end
      end
      if (b_pend) chk("b_stable", 64'({s_axi_bvalid_o, s_axi_bresp_o}), 64'({1'b1, b_hold}));
      b_pend = 1'b0;
      if (s_axi_bvalid_o) begin
        if (!s_axi_bready_i) begin b_pend = 1'b1; b_hold = s_axi_bresp_o; end
        else if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: bvalid seen, expected none");
        end else chk("bresp", 64'(s_axi_bresp_o), 64'(exp_b.pop_front()));
      end

      if (rd_req_push_o) begin
        n_rpush++;
        chk("rd_push_not_full", 64'(rd_req_full_i), 64'(0));
        if (exp_rreq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_push_unexpected: push seen, expected no push");
        end else chk("rd_req_data", 64'(rd_req_data_o), 64'(exp_rreq.pop_front()));
        if (chk_rlat) chk("rd_push_latency", 64'(cyc), 64'(last_arhs + 1));
        rv = r_fix_en ? r_fix_val : {32'($urandom), 2'($urandom_range(3))};
        rresp_q.push_back(rv);
        rresp_t.push_back(cyc + 1 + int'($urandom_range(resp_dly)));
        exp_r.push_back(rv);
      end
      if (prev_rpull) chk("rvalid_after_pull", 64'(s_axi_rvalid_o), 64'(1));
      prev_rpull = rd_resp_pull_o;
      if (rd_resp_pull_o) begin
        n_rpull++;
        chk("rd_pull_not_empty", 64'(rd_resp_empty_i), 64'(0));
        if (rresp_q.size() > 0) begin void'(rresp_q.pop_front()); void'(rresp_t.pop_front()); end
      end
      if (r_pend)
        chk("r_stable", 64'({s_axi_rvalid_o, s_axi_rdata_o, s_axi_rresp_o}), 64'({1'b1, r_hold}));
      r_pend = 1'b0;
      if (s_axi_rvalid_o) begin
        if (!s_axi_rready_i) begin r_pend = 1'b1; r_hold = {s_axi_rdata_o, s_axi_rresp_o}; end
        else if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected: rvalid seen, expected none");
        end else chk("rdata_rresp", 64'({s_axi_rdata_o, s_axi_rresp_o}), 64'(exp_r.pop_front()));
      end
    end
  end

  task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int daw, input int dw);
    int haw, hw;
    haw = -1; hw = -1;
    exp_wreq.push_back(wcode(a, s));
    exp_wdata.push_back({d, s});
    fork
      begin
        if (daw > 0) begin repeat (daw) @(posedge clk_i); #1; end
        s_axi_awaddr_i = a; s_axi_awvalid_i = 1'b1;
        for (int n = 0; n < 300; n++) begin
          @(negedge clk_i);
          if (s_axi_awready_o) begin haw = cyc; break; end
        end
        @(posedge clk_i); #1 s_axi_awvalid_i = 1'b0;
      end
      begin
        if (dw > 0) begin repeat (dw) @(posedge clk_i); #1; end
        s_axi_wdata_i = d; s_axi_wstrb_i = s; s_axi_wvalid_i = 1'b1;
        for (int n = 0; n < 300; n++) begin
          @(negedge clk_i);
          if (s_axi_wready_o) begin hw = cyc; break; end
        end
        @(posedge clk_i); #1 s_axi_wvalid_i = 1'b0;
      end
    join
    last_whs = (haw > hw) ? haw : hw;
    checks++;
    if (haw < 0 || hw < 0) begin
      errors++;
      $display("FAIL aw_w_handshake: aw=%0d w=%0d, expected both accepted", haw, hw);
    end
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] a, input int dar);
    int har;
    har = -1;
    exp_rreq.push_back(a[3:2]);
    if (dar > 0) begin repeat (dar) @(posedge clk_i); #1; end
    s_axi_araddr_i = a; s_axi_arvalid_i = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_i);
      if (s_axi_arready_o) begin har = cyc; break; end
    end
    @(posedge clk_i); #1 s_axi_arvalid_i = 1'b0;
    last_arhs = har;
    checks++;
    if (har < 0) begin
      errors++;
      $display("FAIL ar_handshake: got no arready, expected accepted");
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_b.size() + exp_r.size() + exp_wreq.size() + exp_rreq.size()) > 0 && n < 2000) begin
      @(posedge clk_i); n++;
    end
    #1;
    chk({nm, "_drain"}, 64'(exp_b.size() + exp_r.size() + exp_wreq.size() + exp_rreq.size()), 64'(0));
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_ctrl"}, 64'({s_axi_awready_o, s_axi_wready_o, s_axi_bvalid_o, s_axi_arready_o,
        s_axi_rvalid_o, wr_req_push_o, wr_data_push_o, wr_resp_pull_o, rd_req_push_o, rd_resp_pull_o}),
        64'(0));
    chk({tag, "_data"}, 64'({s_axi_rdata_o, s_axi_bresp_o, s_axi_rresp_o, wr_req_data_o, rd_req_data_o}),
        64'(0));
    chk({tag, "_wdata"}, 64'(wr_data_data_o), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, nr, npw, npr, n;
    #12 rst_checks("reset");
    @(posedge clk_i); #1 reset_n_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    chk("ready_after_reset", 64'({s_axi_awready_o, s_axi_wready_o, s_axi_arready_o}), 64'(3'b111));
    @(posedge clk_i); #1;

    // directed
    chk_wlat = 1'b1; chk_rlat = 1'b1; b_fix_en = 1'b1; r_fix_en = 1'b1;
    b_fix_val = 2'd0;
    axi_write(4'h0, 32'hA5A5_0001, 4'hF, 0, 0);
    drain("w_ctrl");
    b_fix_val = 2'd2;
    axi_write(4'h8, 32'h0000_00C3, 4'hF, 3, 0);
    drain("w_status");

    chk_rlat = 1'b0; rd_full_force = 1'b1;
    r_fix_val = {32'h1234_5678, 2'b00};
    @(posedge clk_i); #1;
    n = n_rpush;
    axi_read(4'hC, 0);
    repeat (5) @(posedge clk_i);
    #1 chk("rd_held_while_full", 64'(n_rpush), 64'(n));
    rd_full_force = 1'b0;
    drain("rd_full");
    chk("rd_single_push", 64'(n_rpush), 64'(n + 1));
    chk_rlat = 1'b1;

    b_fix_en = 1'b0; r_fix_en = 1'b0;
    nw = n_wpush; nr = n_rpush; npw = n_wpull; npr = n_rpull;
    fork
      axi_write(4'h4, 32'h1357_9BDF, 4'hF, 0, 1);
      axi_read(4'h8, 0);
    join
    drain("concurrent");
    chk("conc_wr_push", 64'(n_wpush), 64'(nw + 1));
    chk("conc_rd_push", 64'(n_rpush), 64'(nr + 1));
    chk("conc_wr_pull", 64'(n_wpull), 64'(npw + 1));
    chk("conc_rd_pull", 64'(n_rpull), 64'(npr + 1));

    axi_write(4'h4, 32'h0BAD_F00D, 4'h3, 0, 0);
    drain("w_strb");

    // randomized
    chk_wlat = 1'b0; chk_rlat = 1'b0; full_pct = 25; resp_dly = 4;
    fork
      for (int i = 0; i < 40; i++) begin
        logic [3:0] s;
        s = ($urandom_range(1) != 0) ? 4'hF : 4'($urandom_range(15));
        axi_write(ADDR_W'($urandom), $urandom, s, int'($urandom_range(3)), int'($urandom_range(3)));
      end
      for (int i = 0; i < 40; i++) axi_read(ADDR_W'($urandom), int'($urandom_range(3)));
    join
    drain("random");

    // reset while bvalid is held
    full_pct = 0; resp_dly = 0; hold_bready = 1'b1;
    axi_write(4'hC, 32'hDEAD_BEEF, 4'hF, 0, 0);
    n = 0;
    while (!s_axi_bvalid_o && n < 100) begin @(negedge clk_i); n++; end
    chk("bvalid_before_reset", 64'(s_axi_bvalid_o), 64'(1));
    @(negedge clk_i); #2 reset_n_i = 1'b0;
    #1 rst_checks("midreset");
    exp_wreq.delete(); exp_wdata.delete(); exp_rreq.delete(); exp_b.delete(); exp_r.delete();
    wresp_q.delete(); wresp_t.delete(); rresp_q.delete(); rresp_t.delete();
    prev_wpull = 1'b0; prev_rpull = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
    hold_bready = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk_wlat = 1'b1;
    axi_write(4'h4, 32'h5555_AAAA, 4'hF, 0, 0);
    drain("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
